// File: rtl/digit_serial_subtractor_pkg.sv
// Shared definitions for the digit-serial subtractor.
//   - State encodings for the top-level controller FSM.
//   - clog2: constant-evaluable ceiling log2, used to size the digit counter.
package sub_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_BUSY = ST_BUSY,
        S_DONE = ST_DONE
    } state_e;

    // Ceiling log2; returns 0 for values <= 1.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/digit_serial_subtractor_slice.sv
// Combinational DIGIT-bit ripple-borrow subtractor slice.
// Behaves exactly like DIGIT chained single-bit full subtractors.
// Ports:
//   a, b  in  DIGIT  minuend / subtrahend slice
//   bin   in  1      borrow into the slice LSB
//   diff  out DIGIT  a - b - bin (slice bits)
//   bout  out 1      borrow out of the slice MSB
module digit_subtractor #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             bin,
    output logic [DIGIT-1:0] diff,
    output logic             bout
);

    always_comb begin
        logic borrow;
        borrow = bin;
        diff   = '0;
        for (int i = 0; i < DIGIT; i++) begin
            diff[i] = a[i] ^ b[i] ^ borrow;
            borrow  = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & borrow);
        end
        bout = borrow;
    end

endmodule

// File: rtl/digit_serial_subtractor.sv
// Digit-serial subtractor: diff = a - b - bin over WIDTH bits, DIGIT bits per clock,
// LSB slice first, with valid/ready handshakes on both sides.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    operand handshake (a, b, bin)
//   out_valid/out_ready  result handshake (diff, bout, ovf)
//   diff                 a - b - bin modulo 2^WIDTH
//   bout                 final borrow (unsigned a < b + bin)
//   ovf                  two's-complement overflow
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// BUSY  | one slice per cycle, NDIG cycles
// DONE  | result presented, waiting for out_ready
module digit_serial_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (clog2(NDIG) < 1) ? 1 : clog2(NDIG);
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [DIGIT-1:0] slice_diff;
    logic             slice_bout;
    logic [WIDTH-1:0] acc_next;

    digit_subtractor #(.DIGIT(DIGIT)) u_slice (
        .a    (a_q[DIGIT-1:0]),
        .b    (b_q[DIGIT-1:0]),
        .bin  (borrow_q),
        .diff (slice_diff),
        .bout (slice_bout)
    );

    // Result slices enter at the MSB end; after NDIG shifts the LSB slice sits at bit 0.
    // Written as shift/or so the DIGIT == WIDTH case needs no special slicing.
    assign acc_next = (acc_q >> DIGIT) | (WIDTH'(slice_diff) << (WIDTH - DIGIT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            bout_q   <= bout_d;
            ovf_q    <= ovf_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        bout_d   = bout_q;
        ovf_d    = ovf_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d      = a;
                    b_d      = b;
                    borrow_d = bin;
                    cnt_d    = '0;
                    acc_d    = '0;
                    state_d  = S_BUSY;
                end
            end
            S_BUSY: begin
                a_d      = a_q >> DIGIT;
                b_d      = b_q >> DIGIT;
                acc_d    = acc_next;
                borrow_d = slice_bout;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    // On the last slice, bit DIGIT-1 of the shifted operands is the original MSB.
                    diff_d  = acc_next;
                    bout_d  = slice_bout;
                    ovf_d   = (a_q[DIGIT-1] ^ b_q[DIGIT-1]) &
                              (slice_diff[DIGIT-1] ^ a_q[DIGIT-1]);
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign diff      = diff_q;
    assign bout      = bout_q;
    assign ovf       = ovf_q;

endmodule
